// File: rtl/ceespu_pkg.sv
// Shared types and constants for the ceespu fetch sequencer.
// Address widths are in instruction words.
package ceespu_pkg;

  localparam int unsigned CEESPU_ADDR_W = 14;

  localparam logic [CEESPU_ADDR_W-1:0] CEESPU_RESET_VEC = 14'h0000;
  localparam logic [CEESPU_ADDR_W-1:0] CEESPU_IRQ_VEC   = 14'h0010;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StWait = 2'd2,
    StHalt = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ceespu_pc_next.sv
// Combinational priority mux for the fetch controller: picks the next PC, EPC,
// interrupt enable, fetch state and the flush / irq-ack pulse requests.
module ceespu_pc_next
  import ceespu_pkg::*;
#(
  parameter int unsigned            ADDR_W  = CEESPU_ADDR_W,
  parameter logic [ADDR_W-1:0]      IRQ_VEC = CEESPU_IRQ_VEC
) (
  input  logic [1:0]        state,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] epc,
  input  logic              ie,
  input  logic              stall,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              reti,
  input  logic              irq,
  input  logic              halt,
  input  logic              mem_ready,
  output logic [1:0]        state_next,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] epc_next,
  output logic              ie_next,
  output logic              flush_next,
  output logic              irq_ack_next
);

  fetch_state_e      st;
  fetch_state_e      st_n;
  logic [ADDR_W-1:0] pc_inc;

  assign st         = fetch_state_e'(state);
  assign pc_inc     = pc + ADDR_W'(1);  // wraps silently at the top of memory
  assign state_next = st_n;

  always_comb begin
    st_n         = st;
    pc_next      = pc;
    epc_next     = epc;
    ie_next      = ie;
    flush_next   = 1'b0;
    irq_ack_next = 1'b0;

    case (st)
      StBoot: begin
        st_n    = StRun;
        ie_next = 1'b1;
      end

      StRun, StWait: begin
        if (branch) begin
          pc_next    = branch_addr;
          flush_next = 1'b1;
          st_n       = StRun;
        end else if (reti) begin
          pc_next    = epc;
          ie_next    = 1'b1;
          flush_next = 1'b1;
          st_n       = StRun;
        end else if (irq && ie) begin
          epc_next     = pc;
          pc_next      = IRQ_VEC;
          ie_next      = 1'b0;
          flush_next   = 1'b1;
          irq_ack_next = 1'b1;
          st_n         = StRun;
        end else if (halt) begin
          st_n = StHalt;
        end else if (!stall) begin
          if (!mem_ready) begin
            st_n = StWait;
          end else begin
            pc_next = pc_inc;
            st_n    = StRun;
          end
        end
      end

      StHalt: begin
        // Only an enabled interrupt wakes us; it resumes after the halt.
        if (irq && ie) begin
          epc_next     = pc_inc;
          pc_next      = IRQ_VEC;
          ie_next      = 1'b0;
          flush_next   = 1'b1;
          irq_ack_next = 1'b1;
          st_n         = StRun;
        end
      end

      default: begin
        st_n = StBoot;
      end
    endcase
  end

endmodule

// File: rtl/ceespu_fetch_ctrl.sv
// ceespu PC / instruction-fetch sequencer: owns the PC, EPC and interrupt
// enable, and drives the fetch request, flush and interrupt-ack pulses.
module ceespu_fetch_ctrl
  import ceespu_pkg::*;
#(
  parameter int unsigned       ADDR_W    = CEESPU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = CEESPU_RESET_VEC,
  parameter logic [ADDR_W-1:0] IRQ_VEC   = CEESPU_IRQ_VEC
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_stall,
  input  logic              I_branch,
  input  logic [ADDR_W-1:0] I_branchAddress,
  input  logic              I_reti,
  input  logic              I_irq,
  input  logic              I_halt,
  input  logic              I_mem_ready,
  output logic [ADDR_W-1:0] O_PC,
  output logic              O_fetch_valid,
  output logic              O_flush,
  output logic              O_irq_ack,
  output logic [ADDR_W-1:0] O_epc,
  output logic              O_halted
);

  fetch_state_e      state_q;
  logic [1:0]        state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              ie_q, ie_d;
  logic              flush_q, flush_d;
  logic              irq_ack_q, irq_ack_d;

  ceespu_pc_next #(
    .ADDR_W  (ADDR_W),
    .IRQ_VEC (IRQ_VEC)
  ) u_pc_next (
    .state        (state_q),
    .pc           (pc_q),
    .epc          (epc_q),
    .ie           (ie_q),
    .stall        (I_stall),
    .branch       (I_branch),
    .branch_addr  (I_branchAddress),
    .reti         (I_reti),
    .irq          (I_irq),
    .halt         (I_halt),
    .mem_ready    (I_mem_ready),
    .state_next   (state_d),
    .pc_next      (pc_d),
    .epc_next     (epc_d),
    .ie_next      (ie_d),
    .flush_next   (flush_d),
    .irq_ack_next (irq_ack_d)
  );

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q   <= StBoot;
      pc_q      <= RESET_VEC;
      epc_q     <= '0;
      ie_q      <= 1'b0;
      flush_q   <= 1'b0;
      irq_ack_q <= 1'b0;
    end else begin
      state_q   <= fetch_state_e'(state_d);
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      ie_q      <= ie_d;
      flush_q   <= flush_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  always_comb begin
    O_PC          = pc_q;
    O_epc         = epc_q;
    O_flush       = flush_q;
    O_irq_ack     = irq_ack_q;
    O_halted      = (state_q == StHalt);
    // WAIT keeps the request up so imem can finish the pending word.
    O_fetch_valid = (state_q == StRun) || (state_q == StWait);
  end

endmodule

// File: tb/tb_ceespu_fetch_ctrl.sv
// Bench for ceespu_fetch_ctrl: directed scenarios plus random traffic, all
// compared each cycle against a behavioural model of the fetch sequencer.
module tb_ceespu_fetch_ctrl;

  localparam logic [13:0] IRQ_V = 14'h0010;

  logic        clk = 1'b0;
  logic        rst_n, stall, branch, reti, irq, halt, mem_ready;
  logic [13:0] baddr;
  logic [13:0] pc, epc;
  logic        fetch_valid, flush, irq_ack, halted;

  int n_cmp = 0;
  int n_err = 0;

  // Model state, described in terms of observable behaviour.
  bit          m_boot, m_halt, m_ie, m_flush, m_ack;
  logic [13:0] m_pc, m_epc;

  always #5 clk = ~clk;

  ceespu_fetch_ctrl dut (
    .I_clk           (clk),
    .I_rst_n         (rst_n),
    .I_stall         (stall),
    .I_branch        (branch),
    .I_branchAddress (baddr),
    .I_reti          (reti),
    .I_irq           (irq),
    .I_halt          (halt),
    .I_mem_ready     (mem_ready),
    .O_PC            (pc),
    .O_fetch_valid   (fetch_valid),
    .O_flush         (flush),
    .O_irq_ack       (irq_ack),
    .O_epc           (epc),
    .O_halted        (halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic enter_irq(input logic [13:0] ret);
    m_epc  = ret;
    m_pc   = IRQ_V;
    m_ie   = 0;
    m_halt = 0;
    m_ack  = 1;
    m_flush = 1;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_boot = 1; m_halt = 0; m_ie = 0; m_flush = 0; m_ack = 0;
      m_pc = 14'h0000; m_epc = 14'h0000;
      return;
    end
    m_flush = 0;
    m_ack   = 0;
    if (m_boot) begin
      m_boot = 0;
      m_ie   = 1;
    end else if (m_halt) begin
      if (irq && m_ie) enter_irq(m_pc + 14'd1);
    end else if (branch) begin
      m_pc = baddr; m_flush = 1;
    end else if (reti) begin
      m_pc = m_epc; m_ie = 1; m_flush = 1;
    end else if (irq && m_ie) begin
      enter_irq(m_pc);
    end else if (halt) begin
      m_halt = 1;
    end else if (!stall && mem_ready) begin
      m_pc = m_pc + 14'd1;
    end
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("epc", epc, m_epc);
    check("fetch_valid", fetch_valid, !m_boot && !m_halt);
    check("flush", flush, m_flush);
    check("irq_ack", irq_ack, m_ack);
    check("halted", halted, m_halt);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit b, input logic [13:0] a, input bit rt, input bit iq,
                       input bit h, input bit s, input bit mr);
    branch = b; baddr = a; reti = rt; irq = iq; halt = h; stall = s; mem_ready = mr;
  endtask

  task automatic idle();
    drive(0, 14'h0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst_n = 0;
    idle();

    // Reset and boot
    repeat (3) step();
    check("rst_pc", pc, 14'h0000);
    check("rst_fv", fetch_valid, 0);
    rst_n = 1;
    step();
    check("boot_fv", fetch_valid, 1);
    check("boot_pc", pc, 14'h0000);
    step();
    check("first_inc", pc, 14'h0001);

    // Branch, then branch with stall in the same cycle
    drive(1, 14'h0005, 0, 0, 0, 0, 1); step();
    drive(0, 14'h0, 0, 0, 0, 1, 1);    step(); step();
    check("at_5", pc, 14'h0005);
    drive(1, 14'h0123, 0, 0, 0, 1, 1); step();
    check("br_stall_pc", pc, 14'h0123);
    check("br_flush", flush, 1);
    drive(0, 14'h0, 0, 0, 0, 1, 1);    step();
    check("flush_1cyc", flush, 0);

    // Interrupt entry, held irq, return
    drive(1, 14'h0040, 0, 0, 0, 0, 1); step();
    drive(0, 14'h0, 0, 0, 0, 1, 1);    step();
    drive(0, 14'h0, 0, 1, 0, 0, 1);    step();
    check("irq_pc", pc, 14'h0010);
    check("irq_epc", epc, 14'h0040);
    check("irq_ack", irq_ack, 1);
    step();
    check("irq_noreenter_ack", irq_ack, 0);
    check("irq_noreenter_pc", pc, 14'h0011);
    drive(0, 14'h0, 1, 0, 0, 0, 1);    step();
    check("reti_pc", pc, 14'h0040);

    // Branch and irq together: branch first, irq next cycle
    drive(1, 14'h0200, 0, 1, 0, 0, 1); step();
    check("brirq_pc1", pc, 14'h0200);
    drive(0, 14'h0, 0, 1, 0, 0, 1);    step();
    check("brirq_pc2", pc, 14'h0010);
    check("brirq_epc", epc, 14'h0200);
    drive(0, 14'h0, 1, 0, 0, 0, 1);    step();

    // Memory wait at the top of memory, then wrap
    drive(1, 14'h3FFF, 0, 0, 0, 0, 1); step();
    drive(0, 14'h0, 0, 0, 0, 0, 0);    step(); step();
    check("wait_pc", pc, 14'h3FFF);
    check("wait_fv", fetch_valid, 1);
    idle();                            step();
    check("wrap_pc", pc, 14'h0000);

    // Halt, frozen PC, wake on interrupt
    drive(1, 14'h0080, 0, 0, 0, 0, 1); step();
    drive(0, 14'h0, 0, 0, 1, 0, 1);    step();
    check("halted", halted, 1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 14'($urandom), 0, 0, $urandom_range(0, 1), 0, 1);
      step();
    end
    check("halt_frozen", pc, 14'h0080);
    drive(0, 14'h0, 0, 1, 0, 0, 1);    step();
    check("wake_pc", pc, 14'h0010);
    check("wake_epc", epc, 14'h0081);
    check("wake_halted", halted, 0);

    // Halt with interrupts disabled sticks until reset
    drive(0, 14'h0, 0, 0, 1, 0, 1);    step();
    drive(0, 14'h0, 0, 1, 0, 0, 1);    step(); step();
    check("stuck_halt", halted, 1);
    rst_n = 0;                         step();
    check("rst_halt_pc", pc, 14'h0000);
    check("rst_halt_h", halted, 0);
    check("rst_halt_fv", fetch_valid, 0);
    rst_n = 1; idle();                 step();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      branch    = ($urandom_range(0, 7) == 0);
      baddr     = 14'($urandom);
      reti      = ($urandom_range(0, 15) == 0);
      irq       = ($urandom_range(0, 5) == 0);
      halt      = ($urandom_range(0, 39) == 0);
      stall     = ($urandom_range(0, 4) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ceespu_fetch_ctrl.md
Name: ceespu_fetch_ctrl

Overview:
Sequencing controller for the ceespu program counter and instruction fetch. It owns the PC register and arbitrates between the redirect sources that compete for it each cycle: execute-stage branch, return-from-interrupt, external interrupt, halt, hazard stall and instruction-memory wait. It sits between the hazard/execute logic and instruction memory, and drives O_PC, the fetch request and the pipeline flush.

Parameters:
ADDR_W, 14, PC / instruction address width in words
RESET_VEC, 14'h0000, PC value after reset
IRQ_VEC, 14'h0010, interrupt handler entry address

Ports:
I_clk  in  1  clock, all state on rising edge
I_rst_n  in  1  synchronous reset, active-low
I_stall  in  1  hazard stall from decode; hold PC
I_branch  in  1  taken branch/jump from execute
I_branchAddress  in  ADDR_W  branch target
I_reti  in  1  return-from-interrupt executed
I_irq  in  1  level-sensitive external interrupt request
I_halt  in  1  halt instruction executed
I_mem_ready  in  1  imem returns the word at O_PC this cycle
O_PC  out  ADDR_W  current fetch address
O_fetch_valid  out  1  fetch request to imem at O_PC
O_flush  out  1  one-cycle pulse; kill IF/ID contents
O_irq_ack  out  1  one-cycle pulse on interrupt entry
O_epc  out  ADDR_W  saved return address
O_halted  out  1  high while in HALT

Behaviour:
- Reset (I_rst_n=0 at edge, overrides everything, including mid-redirect or mid-wait): state=BOOT, O_PC=RESET_VEC, O_epc=0, internal ie=0, O_fetch_valid=0, O_flush=0, O_irq_ack=0, O_halted=0.
- States: BOOT, RUN, WAIT, HALT.
- BOOT: lasts one cycle after reset release, then RUN with O_fetch_valid=1 and ie=1. PC is unchanged.
- RUN/WAIT redirect priority, evaluated each cycle, highest first:
  1. I_branch: O_PC<=I_branchAddress; O_flush=1 next cycle.
  2. I_reti: O_PC<=O_epc, ie<=1, O_flush=1.
  3. I_irq&&ie: O_epc<=O_PC, O_PC<=IRQ_VEC, ie<=0, O_irq_ack=1, O_flush=1.
  4. I_halt: go to HALT; O_fetch_valid<=0; PC held.
  5. I_stall: hold PC.
  6. !I_mem_ready: go to WAIT, hold PC, keep O_fetch_valid=1.
  7. Otherwise: O_PC<=O_PC+1, and state is RUN.
- Every redirect (items 1-3) returns the state to RUN.
- Deferred interrupt: a branch and an interrupt in the same cycle take the branch. The interrupt is taken the following cycle with O_epc=branch target.
- I_reti and I_irq in the same cycle: reti wins; the interrupt enters the next cycle (ie=1 again), so O_epc=old epc.
- WAIT: hold PC until I_mem_ready=1; then increment (unless stalled) and return to RUN. Redirects pre-empt WAIT.
- HALT: O_halted=1, O_fetch_valid=0, PC frozen.
  - Exit only on I_irq&&ie: the interrupt entry sequence runs with O_epc=halted PC+1 (resume after halt), and the state goes to RUN.
  - With ie=0 the controller stays halted until reset.
- O_flush and O_irq_ack are registered, exactly one cycle wide, and never asserted in BOOT or HALT.
- PC increment wraps modulo 2^ADDR_W (3FFF+1 -> 0000), with no flag.
- I_stall has no effect on a redirect in the same cycle; the redirect wins.

Decomposition:
- Shared package ceespu_pkg holds:
  - fetch-state enum (BOOT, RUN, WAIT, HALT)
  - CEESPU_ADDR_W=14
  - CEESPU_RESET_VEC and CEESPU_IRQ_VEC constants
- Natural sub-module: ceespu_pc_next, a combinational priority mux producing next PC, next state and pulse enables.
- The top holds the registers and state machine.

Test Plan:
- Reset: I_rst_n low 3 cycles then high -> O_PC=0000, fetch_valid 0 for one cycle, then 1. Next cycle with mem_ready=1, O_PC=0001.
- Branch + stall: at PC=0005 assert I_branch, I_branchAddress=0123, I_stall=1 -> O_PC=0123, O_flush=1 for exactly one cycle.
- Interrupt:
  - At PC=0040 assert I_irq -> O_PC=0010, O_epc=0040, O_irq_ack pulse.
  - Holding I_irq does not re-enter.
  - I_reti -> O_PC=0040.
- Branch + irq same cycle: target 0200 -> cycle 1 O_PC=0200; cycle 2 O_PC=0010, O_epc=0200.
- Mem wait / wrap:
  - O_PC=3FFF, mem_ready=0 for 2 cycles -> PC held at 3FFF, fetch_valid=1.
  - mem_ready=1 -> O_PC=0000.
- Halt:
  - I_halt at PC=0080 -> O_halted=1, PC frozen 10 cycles.
  - I_irq -> O_PC=0010, O_epc=0081, O_halted=0.
  - Reset asserted during HALT -> O_PC=0000, state BOOT.
